// File: rtl/uni_shift_seq.sv
// uni_shift_seq: sequential universal shift engine, one position per clock for a latched count and mode
module uni_shift_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic [WIDTH-1:0] ip,
  input  logic             load,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic             ser_in,
  output logic [WIDTH-1:0] op,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state;
  logic [2:0]       mode_q;
  logic [AMT_W-1:0] cnt;
  logic             left, fill_l, fill_r, sh_bit;
  logic [WIDTH-1:0] sh_op;
  always_comb begin
    left   = mode_q == 3'b000 || mode_q == 3'b011 || mode_q == 3'b101;
    fill_l = mode_q == 3'b011 ? op[WIDTH-1] : mode_q == 3'b101 ? ser_in : 1'b0;
    fill_r = mode_q == 3'b010 ? op[WIDTH-1] : mode_q == 3'b100 ? op[0] :
             mode_q == 3'b110 ? ser_in : 1'b0;
    sh_op  = mode_q == 3'b111 ? op : left ? {op[WIDTH-2:0], fill_l} : {fill_r, op[WIDTH-1:1]};
    sh_bit = mode_q == 3'b111 ? ser_out : left ? op[WIDTH-1] : op[0];
  end
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state   <= IDLE;
      mode_q  <= '0;
      cnt     <= '0;
      op      <= '0;
      ser_out <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (load) begin
          op      <= ip;
          ser_out <= 1'b0;
        end else if (start) begin
          if (amt == '0) begin
            done <= 1'b1;
          end else begin
            mode_q <= mode;
            cnt    <= amt;
            state  <= SHIFT;
            busy   <= 1'b1;
          end
        end
      end else begin
        op      <= sh_op;
        ser_out <= sh_bit;
        cnt     <= cnt - 1'b1;
        if (cnt == AMT_W'(1)) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/uni_shift_seq.md
# uni_shift_seq

Parametrised sequential universal shift engine, the next generation of our 8-bit universal shift register. It adds a programmable shift width, multi-position shift counts, arithmetic and serial-fill modes, and a start/busy/done handshake. A loaded word is shifted one position per clock for `amt` cycles in the latched mode, with the last ejected bit exposed on `ser_out`. It sits in datapaths that need variable shifts without a full barrel shifter, and in serializer front-ends.

## Interface
- `WIDTH`, default 8: data width in bits, ≥2.
- `AMT_W`, default 4: width of the shift-count input; the maximum count is 2^AMT_W−1.

- `clk`  in  1  rising-edge clock, the single clock domain.
- `rst_a`  in  1  asynchronous reset, active-low.
- `ip`  in  WIDTH  parallel load data.
- `load`  in  1  load `ip` into the register; honoured only in IDLE.
- `start`  in  1  begin a shift operation; honoured only in IDLE.
- `mode`  in  3  shift mode, latched at start.
- `amt`  in  AMT_W  number of single-bit shifts, latched at start.
- `ser_in`  in  1  fill bit for serial modes, sampled on every shift edge.
- `op`  out  WIDTH  register contents.
- `ser_out`  out  1  bit ejected by the most recent shift.
- `busy`  out  1  a shift sequence is in progress.
- `done`  out  1  one-cycle pulse at the end of an operation.

## Operation
- Modes:
  - 000 SLL: shift left, LSB←0.
  - 001 SRL: shift right, MSB←0.
  - 010 SRA: shift right, MSB replicated.
  - 011 ROL: rotate left.
  - 100 ROR: rotate right.
  - 101 SLS: shift left, LSB←`ser_in`.
  - 110 SRS: shift right, MSB←`ser_in`.
  - 111: reserved. Each step leaves `op` and `ser_out` unchanged, but the count still runs and `done` still fires.
- Ejected bit, written to `ser_out` on each shift:
  - left-moving modes (SLL, ROL, SLS): old MSB.
  - right-moving modes (SRL, SRA, ROR, SRS): old LSB.
- State machine:
  - IDLE:
    - `load`=1: `op`←`ip`, `ser_out`←0, stay in IDLE.
    - else `start`=1 with `amt`=0: `done` pulses, `op` unchanged, stay in IDLE.
    - else `start`=1 with `amt`≠0: latch `mode`, `cnt`←`amt`, go to SHIFT.
    - `load` has priority over `start` when both are high.
  - SHIFT:
    - each edge performs one shift and decrements `cnt`.
    - on the edge that takes `cnt` from 1 to 0, go to IDLE and assert `done`.
    - `load`, `start`, `mode` and `amt` are ignored while in SHIFT.
- Counts above WIDTH are legal and run the full `amt` steps. For example SLL by 9 with WIDTH=8 yields all zeros, and a rotate by WIDTH returns the original value.
- Reset:
  - `rst_a` low, asynchronously and at any time including mid-SHIFT: `op`=0, `ser_out`=0, `busy`=0, `done`=0, `cnt`=0, state=IDLE.
  - Deassertion is sampled on `clk`; the first active edge is the first one with `rst_a` high.

## Timing
- `busy` is registered and equals (state==SHIFT).
- `start` sampled at edge k with `amt`=N≥1:
  - `busy`=1 after edge k.
  - shifts occur at edges k+1 … k+N.
  - after edge k+N: `busy`=0, `done`=1 for exactly one cycle, `op` holds the final result.
- `amt`=0: `done`=1 after edge k, `busy` never rises.
- Back-to-back: a `start` or `load` sampled in the cycle where `done`=1 is accepted, because the state is already IDLE. The minimum issue interval is N+1 edges.
- `load` has 1-cycle latency: `op`=`ip` after the sampling edge.
- `ser_in` is sampled at the edge that performs the shift, not at `start`.
- No combinational path from inputs to outputs.

## Test plan
- Reset: start SLL `amt`=5, then pull `rst_a` low between edges at step 2 → immediately `op`=0, `busy`=0, `done`=0, `ser_out`=0 without waiting for a clock edge. After release, IDLE accepts a new `load`.
- ROL: load 8'b11001100, start `mode`=011 `amt`=3 → `busy` high for 3 cycles; `op`=8'b01100110, `ser_out`=0; single `done` pulse after edge k+3.
- SRA: load 8'b10001100, `mode`=010 `amt`=2 → `op`=8'b11100011, `ser_out`=0. Follow with SRL `amt`=2 issued on the `done` cycle → `op`=8'b00111000, `ser_out`=1.
- Over-width count: load 8'b11110000, SLL `amt`=9 → `busy` for 9 cycles, `op`=8'h00, `ser_out`=0. Separately, ROR `amt`=8 on 8'b10101101 → `op` unchanged, `ser_out`=1.
- Zero count and ignored inputs:
  - start with `amt`=0 → `done` after 1 edge, `busy` never high, `op` unchanged.
  - during a SHIFT, pulse `load` with `ip`=8'hFF and pulse `start` → both have no effect, and the sequence completes with the originally latched mode and count.
- Serial fill: load 8'h00, `mode`=101 `amt`=4, `ser_in`=1 then 0,1,1 on successive edges → `op`=8'b00001011. Also check that `load`+`start` together in IDLE performs only the load.
